uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 28, clock cycles per serial bit (3.226 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL have parameter DATA_BITS, fixed at 8, payload bits per frame.
REQ-003 SHALL have port i_clk, input, 1, single clock for all logic.
REQ-004 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_data, input, 8, byte to transmit.
REQ-006 SHALL have port i_valid, input, 1, i_data valid this cycle.
REQ-007 SHALL have port o_ready, output, 1, holding register can accept a byte.
REQ-008 SHALL have port o_tx, output, 1, serial line, idle high.
REQ-009 SHALL have port o_busy, output, 1, frame in progress or byte held.
REQ-010 SHALL have port o_done, output, 1, one-cycle pulse on the last cycle of each stop bit.

Function
REQ-011 SHALL frame as 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity, 10 bits per frame.
REQ-012 SHALL hold each bit on o_tx for exactly CLKS_PER_BIT cycles; a frame occupies 10*CLKS_PER_BIT cycles.
REQ-013 SHALL drive o_tx from a register (no combinational path from inputs to o_tx).
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP; IDLE->START on shifter load; START->DATA, DATA->STOP after bit index 7, STOP->IDLE or STOP->START (buffered byte), each on baud-counter terminal count.
REQ-015 SHALL use a baud counter counting 0..CLKS_PER_BIT-1, cleared on every state entry, and a 3-bit bit index wrapping 7->0 on DATA exit.
REQ-016 SHALL accept a byte on a rising edge when i_valid && o_ready; i_data is ignored otherwise.
REQ-017 SHALL contain one holding register; o_ready = holding register empty.
REQ-018 If accepted while FSM is IDLE, the byte SHALL load directly into the shifter, and o_tx SHALL go low on the cycle after the accepting edge.
REQ-019 If accepted while a frame is in progress, the byte SHALL enter the holding register and o_ready SHALL drop the next cycle.
REQ-020 On STOP terminal count with the holding register full, the FSM SHALL go directly to START with no idle gap, and the register SHALL empty (o_ready high the next cycle).
REQ-021 Accept on the same edge as STOP terminal count with an empty holding register SHALL load the shifter directly (back-to-back, no gap).
REQ-022 o_busy SHALL be high when FSM != IDLE or the holding register is full.
REQ-023 o_done SHALL pulse for exactly one cycle per frame, including back-to-back frames.
REQ-024 i_valid held high with ready low SHALL NOT corrupt or drop the in-flight or held byte.

Reset
REQ-025 While i_rst_n=0: o_tx=1, o_ready=1, o_busy=0, o_done=0, FSM=IDLE, counters=0, holding register empty; the effect is immediate and asynchronous.
REQ-026 Reset asserted mid-frame SHALL abort the frame and discard the held byte; o_tx SHALL return high without a glitch low.
REQ-027 After reset release, the first byte SHALL be accepted on the first edge with i_valid=1.

Verification
REQ-028 CLKS_PER_BIT=4, send 0x55 from idle -> o_tx = 0,1,0,1,0,1,0,1,0,1, each 4 cycles (40 cycles total); o_done high on cycle 40 only; o_busy low after.
REQ-029 CLKS_PER_BIT=4, send 0xA3 then 0x0F with i_valid held -> second byte held (o_ready low); its start bit follows the first stop bit with zero gap; 80 cycles total; two o_done pulses.
REQ-030 Three bytes 0x01,0x02,0x03 with i_valid continuously high -> third accepted only after the holding register drains into the shifter; all three frames correct on o_tx in order.
REQ-031 Assert i_rst_n=0 during DATA bit 3 of 0xFF with a byte held -> o_tx=1 immediately, o_ready=1, o_busy=0; after release, 0x00 transmits cleanly.
REQ-032 Default CLKS_PER_BIT=28, random 256-byte stream into a reference 8N1 sampler at mid-bit -> all bytes match, no framing errors.

Source files
------------

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   8N1 UART transmitter with one byte of buffering. A byte offered while the
//   line is idle goes straight into the shift register. A byte offered while a
//   frame is on the wire waits in a single holding register. That byte is
//   launched with no idle gap when the current stop bit ends.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (2..65535), default 28
//   DATA_BITS    : payload bits per frame, fixed at 8
//
// Ports
//   i_clk    : single clock for all logic
//   i_rst_n  : asynchronous active-low reset
//   i_data   : byte to transmit
//   i_valid  : i_data valid this cycle; taken on a rising edge when o_ready=1
//   o_ready  : holding register empty, a byte can be accepted
//   o_tx     : serial line, idle high, driven straight from a flop
//   o_busy   : frame in progress or a byte waiting in the holding register
//   o_done   : one-cycle pulse on the last cycle of each stop bit
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 28,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  // The counter width covers 0..CLKS_PER_BIT-1. CLKS_PER_BIT >= 2 keeps it >= 1 bit.
  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  // o_done is registered, so it is set one count early. It is then high exactly
  // while the stop bit sits on its terminal count.
  localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(CLKS_PER_BIT - 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_hold;
  logic                 r_hold_full;
  logic                 r_tx;
  logic                 r_done;

  logic w_accept;
  logic w_tc;
  logic w_stop_tc;
  logic w_load_direct;
  logic w_to_hold;

  // A byte is only ever accepted into an empty holding register.
  assign w_accept  = i_valid & ~r_hold_full;
  assign w_tc      = (r_cnt == LAST_CNT);
  assign w_stop_tc = (r_state == S_STOP) & w_tc;

  // A byte bypasses the holding register when the shifter is free this edge.
  // That happens when the line is idle, or when the stop bit ends with nothing
  // already waiting. The second case gives back-to-back frames without a
  // round trip through the holding register.
  assign w_load_direct = w_accept & ((r_state == S_IDLE) | w_stop_tc);
  assign w_to_hold     = w_accept & ~w_load_direct;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_tx        <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_to_hold) begin
        r_hold      <= i_data;
        r_hold_full <= 1'b1;
      end

      unique case (r_state)
        S_IDLE: begin
          if (w_load_direct) begin
            r_shift <= i_data;
            r_cnt   <= '0;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end

        S_START: begin
          if (w_tc) begin
            r_cnt   <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (w_tc) begin
            r_cnt <= '0;
            // The shifter moves right so the next bit is always at index 1.
            // The bit index wraps 7->0 as the frame leaves the data phase.
            r_shift   <= r_shift >> 1;
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_tx <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (r_cnt == DONE_CNT) begin
            r_done <= 1'b1;
          end
          if (w_tc) begin
            r_cnt <= '0;
            if (r_hold_full) begin
              // Drain the waiting byte. The holding register frees up, so
              // o_ready rises on the next cycle.
              r_shift     <= r_hold;
              r_hold_full <= 1'b0;
              r_tx        <= 1'b0;
              r_state     <= S_START;
            end else if (w_load_direct) begin
              r_shift <= i_data;
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_tx    = r_tx;
  assign o_done  = r_done;
  assign o_ready = ~r_hold_full;
  assign o_busy  = (r_state != S_IDLE) | r_hold_full;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//   Bench for uart_tx. One instance uses CLKS_PER_BIT=4 for cycle-exact
//   waveform checks. That instance also covers buffering and reset behaviour.
//   A second instance uses the default CLKS_PER_BIT=28. It receives a random
//   byte stream, which a mid-bit 8N1 sampler decodes.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int C4  = 4;
  localparam int C28 = 28;
  localparam int F4  = 10 * C4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst_n, a_valid, a_ready, a_tx, a_busy, a_done;
  logic [7:0] a_data;
  logic       b_rst_n, b_valid, b_ready, b_tx, b_busy, b_done;
  logic [7:0] b_data;

  uart_tx #(.CLKS_PER_BIT(C4)) u_dut4 (
    .i_clk(clk), .i_rst_n(a_rst_n), .i_data(a_data), .i_valid(a_valid),
    .o_ready(a_ready), .o_tx(a_tx), .o_busy(a_busy), .o_done(a_done)
  );

  uart_tx u_dut28 (
    .i_clk(clk), .i_rst_n(b_rst_n), .i_data(b_data), .i_valid(b_valid),
    .o_ready(b_ready), .o_tx(b_tx), .o_busy(b_busy), .o_done(b_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bit k (0..9) of an 8N1 frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  logic [7:0] tx_q[$];
  int         acc_q[$];
  logic       rdy_c2;

  // The task is entered just after a rising edge. It offers tx_q in order,
  // keeping i_valid high. While o_ready is low it drives junk on i_data. It
  // records the cycle of each accepting edge. Cycle 0 ends with the first
  // accepting edge. The frames must then appear back to back from cycle 1.
  task automatic run_stream(input string name);
    int idx;
    int ncyc;
    int j;
    int k;
    idx  = 0;
    ncyc = tx_q.size() * F4;
    acc_q.delete();
    a_valid = 1'b1;
    a_data  = tx_q[0];
    for (int c = 0; c <= ncyc + 1; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= ncyc) begin
        j = (c - 1) / F4;
        k = ((c - 1) % F4) / C4;
        check({name, "_tx"},   32'(a_tx),   32'(frame_bit(tx_q[j], k)));
        check({name, "_done"}, 32'(a_done), 32'((c % F4) == 0));
        check({name, "_busy"}, 32'(a_busy), 32'd1);
      end else if (c == ncyc + 1) begin
        check({name, "_idle_tx"},   32'(a_tx),   32'd1);
        check({name, "_idle_busy"}, 32'(a_busy), 32'd0);
        check({name, "_idle_done"}, 32'(a_done), 32'd0);
      end
      if (c == 2) rdy_c2 = a_ready;
      if (a_valid && a_ready) begin
        acc_q.push_back(c);
        idx++;
      end
      @(posedge clk);
      #1;
      if (idx < tx_q.size()) begin
        a_valid = 1'b1;
        a_data  = a_ready ? tx_q[idx] : 8'($urandom);
      end else begin
        a_valid = 1'b0;
      end
    end
  endtask

  // Reference 8N1 receiver for the default-rate instance. It samples every
  // bit at its middle.
  logic [7:0] rx_q[$];
  logic [7:0] mon_byte;
  int         ferr     = 0;
  int         done_cnt = 0;

  initial begin : rx_sampler
    forever begin
      @(negedge clk);
      if (b_rst_n === 1'b1 && b_tx === 1'b0) begin
        repeat (C28 / 2) @(negedge clk);
        if (b_tx !== 1'b0) ferr++;
        for (int i = 0; i < 8; i++) begin
          repeat (C28) @(negedge clk);
          mon_byte[i] = b_tx;
        end
        repeat (C28) @(negedge clk);
        if (b_tx !== 1'b1) ferr++;
        rx_q.push_back(mon_byte);
      end
    end
  end

  initial begin : done_counter
    forever begin
      @(negedge clk);
      if (b_done === 1'b1) done_cnt++;
    end
  end

  logic [7:0] exp_q[$];

  initial begin
    logic [7:0] d;
    int         waited;

    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    a_data  = '0;   b_data  = '0;
    rdy_c2  = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx",    32'(a_tx),    32'd1);
    check("rst_ready", 32'(a_ready), 32'd1);
    check("rst_busy",  32'(a_busy),  32'd0);
    check("rst_done",  32'(a_done),  32'd0);
    check("rst_tx28",  32'(b_tx),    32'd1);
    check("rst_rdy28", 32'(b_ready), 32'd1);

    @(posedge clk); #1;
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;

    // Single byte from idle. It must be taken on the first edge after release.
    tx_q = '{8'h55};
    run_stream("b55");
    check("b55_nacc", 32'(acc_q.size()), 32'd1);
    check("b55_acc0", 32'(acc_q[0]),     32'd0);

    repeat (3) @(posedge clk); #1;

    // Second byte is held, then follows with zero gap
    tx_q = '{8'hA3, 8'h0F};
    run_stream("b2");
    check("b2_nacc",   32'(acc_q.size()), 32'd2);
    check("b2_acc1",   32'(acc_q[1]),     32'd1);
    check("b2_rdy_c2", 32'(rdy_c2),       32'd0);

    repeat (2) @(posedge clk); #1;

    // Three bytes. The third waits until the holding register drains at the
    // end of frame 1.
    tx_q = '{8'h01, 8'h02, 8'h03};
    run_stream("b3");
    check("b3_nacc", 32'(acc_q.size()), 32'd3);
    check("b3_acc1", 32'(acc_q[1]),     32'd1);
    check("b3_acc2", 32'(acc_q[2]),     32'd41);

    // Reset during data bit 3 of 0xFF with 0x5A held
    @(posedge clk); #1;
    a_valid = 1'b1; a_data = 8'hFF;
    @(posedge clk); #1;
    a_data = 8'h5A;
    @(posedge clk); #1;
    a_valid = 1'b0;
    repeat (16) @(posedge clk);
    @(negedge clk);
    check("mid_pre_tx",    32'(a_tx),    32'd1);
    check("mid_pre_ready", 32'(a_ready), 32'd0);
    check("mid_pre_busy",  32'(a_busy),  32'd1);
    #1 a_rst_n = 1'b0;
    #1;
    check("mid_rst_tx",    32'(a_tx),    32'd1);
    check("mid_rst_ready", 32'(a_ready), 32'd1);
    check("mid_rst_busy",  32'(a_busy),  32'd0);
    check("mid_rst_done",  32'(a_done),  32'd0);
    repeat (2) @(posedge clk); #1;
    a_rst_n = 1'b1;

    tx_q = '{8'h00};
    run_stream("b00");
    check("b00_acc0", 32'(acc_q[0]), 32'd0);

    // Reset during a start bit drives the line high at once
    a_valid = 1'b1; a_data = 8'h81;
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(negedge clk);
    check("st_pre_tx", 32'(a_tx), 32'd0);
    #1 a_rst_n = 1'b0;
    #1;
    check("st_rst_tx", 32'(a_tx), 32'd1);
    @(posedge clk); #1;
    a_rst_n = 1'b1;
    repeat (C4 + 1) @(negedge clk);
    check("st_after_tx",   32'(a_tx),   32'd1);
    check("st_after_busy", 32'(a_busy), 32'd0);

    // Random stream at the default rate
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) begin
      d = 8'($urandom);
      if ($urandom_range(7, 0) == 0) begin
        b_valid = 1'b0;
        repeat ($urandom_range(300, 1)) @(posedge clk);
        #1;
      end
      b_valid = 1'b1;
      b_data  = d;
      waited  = 0;
      while (!b_ready && waited < 1000) begin
        @(posedge clk); #1;
        b_data = b_ready ? d : 8'($urandom);
        waited++;
      end
      if (waited >= 1000) begin
        check("rnd_ready_timeout", 32'(waited), 32'd0);
        break;
      end
      exp_q.push_back(d);
      @(posedge clk); #1;
    end
    b_valid = 1'b0;

    for (int t = 0; t < 4000 && rx_q.size() < exp_q.size(); t++) @(posedge clk);
    repeat (2 * C28) @(posedge clk);
    @(negedge clk);

    check("rnd_count", 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check("rnd_byte", {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
    check("rnd_framing", 32'(ferr),     32'd0);
    check("rnd_done",    32'(done_cnt), 32'(exp_q.size()));
    check("rnd_busy",    32'(b_busy),   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
